nonce_scheduler: RTL and testbench

Sequences nonce issue into the skein/keccak mining datapath and checks the returning keccak hash against a leading-zero difficulty target. The datapath carries no valid signal, so this block tracks in-flight nonces with its own latency-matched valid pipe and recovers the nonce of each returning hash from an in-order result counter. It sits between host control and the hash pipeline. It replaces free-running nonce increment with bounded, restartable, abortable searches.

---
 rtl/nonce_scheduler.sv | 102 ++++++++++
 tb/tb_nonce_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: bounded, abortable nonce search with latency-matched result tracking and leading-zero target check
// Ports: clk/rst (async active-high); start/stop requests; nonce_base/nonce_count/target_zeros latched on start;
// hash_in result word from the hash pipe; issue_valid/issue_nonce feed the pipe; busy/found/found_nonce/done/aborted status.
module nonce_scheduler #(
  parameter int PIPE_LAT = 326,
  parameter int NONCE_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_count,
  input  logic [6:0]         target_zeros,
  input  logic [63:0]        hash_in,
  output logic               issue_valid,
  output logic [NONCE_W-1:0] issue_nonce,
  output logic               busy,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               done,
  output logic               aborted
);
  localparam int IW = $clog2(PIPE_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;
  state_t               r_state;
  logic [PIPE_LAT-1:0]  r_vpipe;
  logic [IW-1:0]        r_inflight;
  logic [NONCE_W-1:0]   r_rem;
  logic [NONCE_W-1:0]   r_res;
  logic [6:0]           r_tz;
  logic                 w_res_v;
  logic                 w_match;
  logic [IW-1:0]        w_inf_nxt;
  logic [63:0]          w_mask;
  assign w_res_v   = r_vpipe[PIPE_LAT-1];
  // top r_tz bits set; r_tz is clamped to 64 so a shift of 64 yields a full mask
  assign w_mask    = ~({64{1'b1}} >> r_tz);
  assign w_match   = (r_state == ISSUE || r_state == DRAIN) && w_res_v && ((hash_in & w_mask) == 64'd0);
  assign w_inf_nxt = r_inflight + IW'(issue_valid) - IW'(w_res_v);
  assign busy      = r_state != IDLE || r_inflight != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_vpipe     <= '0;
      r_inflight  <= '0;
      r_rem       <= '0;
      r_res       <= '0;
      r_tz        <= '0;
      issue_valid <= 1'b0;
      issue_nonce <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      r_vpipe    <= {r_vpipe[PIPE_LAT-2:0], issue_valid};
      r_inflight <= w_inf_nxt;
      if (w_res_v) r_res <= r_res + NONCE_W'(1);
      case (r_state)
        IDLE: if (start && !stop) begin
          r_tz        <= target_zeros > 7'd64 ? 7'd64 : target_zeros;
          found       <= 1'b0;
          found_nonce <= '0;
          done        <= 1'b0;
          aborted     <= 1'b0;
          issue_nonce <= nonce_base;
          r_res       <= nonce_base;
          // r_rem counts nonces still to issue after the one currently on issue_nonce
          r_rem       <= nonce_count - NONCE_W'(1);
          issue_valid <= nonce_count != '0;
          r_state     <= nonce_count == '0 ? FLUSH : ISSUE;
        end
        ISSUE, DRAIN: if (w_match) begin
          found       <= 1'b1;
          found_nonce <= r_res;
          issue_valid <= 1'b0;
          r_state     <= FLUSH;
        end else if (stop) begin
          aborted     <= 1'b1;
          issue_valid <= 1'b0;
          r_state     <= FLUSH;
        end else if (r_state == DRAIN) begin
          if (w_inf_nxt == '0) begin
            done    <= 1'b1;
            r_state <= IDLE;
          end
        end else if (r_rem == '0) begin
          issue_valid <= 1'b0;
          r_state     <= DRAIN;
        end else begin
          issue_nonce <= issue_nonce + NONCE_W'(1);
          r_rem       <= r_rem - NONCE_W'(1);
        end
        default: if (w_inf_nxt == '0) begin
          done    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_scheduler.sv
// tb_nonce_scheduler: directed and random searches against an outcome-level reference model
module tb_nonce_scheduler;
  localparam int L = 326;
  localparam int NW = 64;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [NW-1:0] nonce_base = '0;
  logic [NW-1:0] nonce_count = '0;
  logic [6:0]    target_zeros = '0;
  logic [63:0]   hash_in = '0;
  logic          issue_valid;
  logic [NW-1:0] issue_nonce;
  logic          busy;
  logic          found;
  logic [NW-1:0] found_nonce;
  logic          done;
  logic          aborted;
  int            checks = 0;
  int            errors = 0;
  logic [NW:0]   q[$];
  logic [NW-1:0] env_win = '0;
  bit            env_win_en = 1'b0;
  int            env_tz = 64;

  always #5 clk = ~clk;

  nonce_scheduler #(.PIPE_LAT(L), .NONCE_W(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .nonce_base(nonce_base), .nonce_count(nonce_count), .target_zeros(target_zeros),
    .hash_in(hash_in), .issue_valid(issue_valid), .issue_nonce(issue_nonce),
    .busy(busy), .found(found), .found_nonce(found_nonce), .done(done), .aborted(aborted)
  );

  // Matching hashes have exactly tz leading zeros; non-matching ones have a single 1 at the last target bit.
  function automatic logic [63:0] mk_hash(bit m, int tz);
    logic [63:0] h;
    h = {$urandom, $urandom} >> tz;
    if (m && tz < 64) h[63-tz] = 1'b1;
    if (!m && tz > 0) h[64-tz] = 1'b1;
    return h;
  endfunction

  // Datapath model: each issued slot reappears on hash_in exactly L cycles later.
  task automatic next_cycle();
    logic [NW:0] e;
    @(posedge clk);
    #1;
    if (q.size() == L) begin
      e = q.pop_front();
      if (e[NW]) hash_in = mk_hash(env_tz == 0 || (env_win_en && e[NW-1:0] == env_win), env_tz);
      else hash_in = $urandom_range(0, 1) ? 64'd0 : {$urandom, $urandom};
    end else hash_in = {$urandom, $urandom};
  endtask

  task automatic sample();
    @(negedge clk);
    q.push_back({issue_valid, issue_nonce});
  endtask

  task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_search(input logic [NW-1:0] base, input int cnt, input int tgt, input int win_k, input int stop_at);
    int tz, m, n, e, dc;
    bit f, ab;
    tz = tgt > 64 ? 64 : tgt;
    m = -1;
    if (cnt > 0 && tz == 0) m = 0;
    else if (win_k >= 0 && win_k < cnt) m = win_k;
    f = 1'b0;
    ab = 1'b0;
    if (cnt == 0) begin
      n = 0;
      dc = 2;
    end else if (m >= 0 && (stop_at < 1 || 1 + m + L <= stop_at)) begin
      e = 1 + m + L;
      n = cnt < e ? cnt : e;
      f = 1'b1;
      dc = (e + 2 > 1 + n + L) ? e + 2 : 1 + n + L;
    end else if (stop_at >= 1 && stop_at <= cnt + L) begin
      e = stop_at;
      n = cnt < e ? cnt : e;
      ab = 1'b1;
      dc = (e + 2 > 1 + n + L) ? e + 2 : 1 + n + L;
    end else begin
      n = cnt;
      dc = 1 + n + L;
    end
    env_tz = tz;
    env_win_en = win_k >= 0;
    env_win = base + NW'(win_k);
    next_cycle();
    nonce_base = base;
    nonce_count = NW'(cnt);
    target_zeros = 7'(tgt);
    start = 1'b1;
    sample();
    for (int c = 1; c <= dc + 2; c++) begin
      next_cycle();
      start = (c == dc - 1);
      stop = (c == stop_at);
      if (c == 1) begin
        nonce_base = {$urandom, $urandom};
        nonce_count = NW'($urandom_range(0, 3));
        target_zeros = 7'($urandom);
      end
      sample();
      check($sformatf("cyc%0d", c),
            {issue_valid, (c <= n) ? issue_nonce : NW'(0), busy, done},
            {c <= n, (c <= n) ? base + NW'(c - 1) : NW'(0), c < dc, c >= dc});
    end
    start = 1'b0;
    stop = 1'b0;
    check("result", {found, found_nonce, aborted}, {f, f ? base + NW'(m) : NW'(0), ab});
  endtask

  initial begin
    int cnt, tgt, win, sa;
    #12;
    check("reset", {issue_valid, issue_nonce, busy, found, found_nonce, done, aborted}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_search(64'h10, 4, 64, -1, -1);
    run_search(64'h0, 1000, 16, 37, -1);
    run_search(64'hFFFF_FFFF_FFFF_FFFE, 3, 0, -1, -1);
    run_search({$urandom, $urandom}, 0, 5, -1, -1);
    next_cycle();
    nonce_count = 64'd5;
    start = 1'b1;
    stop = 1'b1;
    sample();
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      start = 1'b0;
      stop = 1'b0;
      sample();
      check("idle_start_stop", {issue_valid, busy, done}, 3'b001);
    end
    run_search({$urandom, $urandom}, 1000, 20, 10, 1 + 10 + L);
    run_search({$urandom, $urandom}, 1000, 20, -1, 10);
    run_search({$urandom, $urandom}, 5, 100, 2, -1);
    run_search({$urandom, $urandom}, 1, 64, -1, -1);
    next_cycle();
    nonce_base = 64'hABCD;
    nonce_count = 64'd5;
    target_zeros = 7'd64;
    env_tz = 64;
    env_win_en = 1'b0;
    start = 1'b1;
    sample();
    for (int c = 1; c <= 100; c++) begin
      next_cycle();
      start = 1'b0;
      sample();
    end
    check("pre_rst_busy", {busy, issue_valid}, 2'b10);
    #2 rst = 1'b1;
    #1 check("rst_async", {issue_valid, issue_nonce, busy, found, found_nonce, done, aborted}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    run_search({$urandom, $urandom}, 2, 64, -1, -1);
    for (int i = 0; i < 6; i++) begin
      cnt = $urandom_range(0, 400);
      tgt = $urandom_range(0, 127);
      win = $urandom_range(0, 1) ? -1 : int'($urandom_range(0, cnt + 5));
      sa = $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(1, cnt + L + 20));
      run_search({$urandom, $urandom}, cnt, tgt, win, sa);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
